uwu_stream_filter: RTL and testbench

Parametrised byte-stream text transformer and the successor to the single-mode UART uwuifier. It sits between the UART receiver and transmitter and operates on a valid/ready byte stream. It applies one of four runtime-selectable rewrite modes: passthrough, vowel expansion, r/l substitution, and stutter. Expanded output is buffered in an internal FIFO, and input is throttled by FIFO free space rather than a fixed almost-full threshold.

---
 rtl/uwu_pkg.sv | 33 +++
 rtl/byte_fifo.sv | 55 +++++
 rtl/uwu_stream_filter.sv | 155 +++++++++++++++
 tb/tb_uwu_stream_filter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uwu_pkg.sv
// Shared types, character constants and helpers for the uwu_stream_filter slice.
package uwu_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_OWO     = 2'd1,
    MODE_WAW     = 2'd2,
    MODE_STUTTER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } state_e;

  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_W_LO = 8'h77;
  localparam logic [7:0] CH_W_UP = 8'h57;
  localparam logic [7:0] CH_O_LO = 8'h6F;
  localparam logic [7:0] CH_O_UP = 8'h4F;
  localparam logic [7:0] CH_U_LO = 8'h75;
  localparam logic [7:0] CH_U_UP = 8'h55;
  localparam logic [7:0] CH_R_LO = 8'h72;
  localparam logic [7:0] CH_R_UP = 8'h52;
  localparam logic [7:0] CH_L_LO = 8'h6C;
  localparam logic [7:0] CH_L_UP = 8'h4C;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO with wrap-around pointers and an occupancy output.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push    = i_wr_en && (r_level != LW'(DEPTH));
  assign w_pop     = i_rd_en && (r_level != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_valid   = (r_level != '0);
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uwu_stream_filter.sv
// Byte-stream uwuifier with four rewrite modes and a buffered output FIFO.
// Define UWU_STATS_EN to build the saturating transformed-byte counter.
module uwu_stream_filter
  import uwu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             i_mode,
  input  logic [7:0]             i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic [7:0]             o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [15:0]            o_sub_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_e      r_state;
  state_e      w_next_state;
  mode_e       w_mode;
  logic        r_in_word;
  logic        r_expanded;
  logic [7:0]  r_b1;
  logic [7:0]  r_b2;
  logic [7:0]  w_sub;
  logic [7:0]  w_b0;
  logic [7:0]  w_b1;
  logic [7:0]  w_b2;
  logic        w_expand;
  logic        w_set_exp;
  logic        w_accept;
  logic        w_wr_en;
  logic [7:0]  w_wr_data;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_free;

  assign w_mode     = mode_e'(i_mode);
  assign w_free     = LW'(DEPTH) - w_level;
  assign o_in_ready = (r_state == ST_IDLE) && (w_free >= LW'(3)) && !rst;
  assign w_accept   = i_in_valid && o_in_ready;
  assign o_level    = w_level;

  // Every rewrite yields either one byte or three, so a single flag covers length.
  always_comb begin
    w_sub     = i_in_data;
    w_b0      = i_in_data;
    w_b1      = i_in_data;
    w_b2      = i_in_data;
    w_expand  = 1'b0;
    w_set_exp = 1'b0;
    if ((w_mode == MODE_WAW) || (w_mode == MODE_STUTTER)) begin
      case (i_in_data)
        CH_R_LO, CH_L_LO: w_sub = CH_W_LO;
        CH_R_UP, CH_L_UP: w_sub = CH_W_UP;
        default:          w_sub = i_in_data;
      endcase
    end
    if (w_mode != MODE_PASS) begin
      w_b0 = w_sub;
      w_b1 = w_sub;
      w_b2 = w_sub;
      if ((w_mode == MODE_STUTTER) && is_letter(w_sub) && !r_in_word) begin
        w_expand = 1'b1;
        w_b1     = CH_DASH;
      end else if (((w_sub == CH_O_LO) || (w_sub == CH_U_LO) ||
                    (w_sub == CH_O_UP) || (w_sub == CH_U_UP)) && !r_expanded) begin
        w_expand  = 1'b1;
        w_set_exp = 1'b1;
        w_b1      = ((w_sub == CH_O_UP) || (w_sub == CH_U_UP)) ? CH_W_UP : CH_W_LO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    w_wr_data    = w_b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (w_expand) w_next_state = ST_EMIT1;
        end
      end
      ST_EMIT1: begin
        w_wr_en      = 1'b1;
        w_wr_data    = r_b1;
        w_next_state = ST_EMIT2;
      end
      ST_EMIT2: begin
        w_wr_en      = 1'b1;
        w_wr_data    = r_b2;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_word  <= 1'b0;
      r_expanded <= 1'b0;
      r_b1       <= '0;
      r_b2       <= '0;
    end else if (w_accept) begin
      r_b1       <= w_b1;
      r_b2       <= w_b2;
      r_in_word  <= is_letter(i_in_data);
      r_expanded <= is_letter(i_in_data) ? (r_expanded || w_set_exp) : 1'b0;
    end
  end

  byte_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (i_out_ready),
    .o_rd_data (o_out_data),
    .o_valid   (o_out_valid),
    .o_level   (w_level)
  );

`ifdef UWU_STATS_EN
  logic        w_differs;
  logic [15:0] r_sub_count;

  assign w_differs   = w_expand || (w_b0 != i_in_data);
  assign o_sub_count = r_sub_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub_count <= '0;
    end else if (w_accept && w_differs && (r_sub_count != 16'hFFFF)) begin
      r_sub_count <= r_sub_count + 16'd1;
    end
  end
`else
  assign o_sub_count = '0;
`endif

endmodule

// File: tb/tb_uwu_stream_filter.sv
// Scoreboard bench for uwu_stream_filter: directed strings with hand-computed outputs.
module tb_uwu_stream_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [7:0]  i_in_data;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [7:0]  o_out_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [3:0]  o_level;
  logic [15:0] o_sub_count;

  int          checks = 0;
  int          errors = 0;
  byte unsigned expQ[$];
  bit          ignoreOut = 1'b0;

  uwu_stream_filter #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_mode      (i_mode),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_level     (o_level),
    .o_sub_count (o_sub_count)
  );

  always #5 clk = ~clk;

`ifdef UWU_STATS_EN
  localparam int SC_OWO = 2;
  localparam int SC_WAW = 4;
  localparam int SC_STU = 3;
`else
  localparam int SC_OWO = 0;
  localparam int SC_WAW = 0;
  localparam int SC_STU = 0;
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input string s);
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
  endtask

  // Entered and left at posedge+1 so an input is never presented twice.
  task automatic sendByte(input logic [1:0] m, input logic [7:0] b, output int stalls);
    stalls     = 0;
    i_mode     = m;
    i_in_data  = b;
    i_in_valid = 1'b1;
    @(negedge clk);
    while (!o_in_ready && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!o_in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input string s, input string expect_s,
                               output int totalStalls);
    int st;
    pushExpected(expect_s);
    totalStalls = 0;
    for (int i = 0; i < s.len(); i++) begin
      sendByte(m, s[i], st);
      totalStalls += st;
    end
  endtask

  task automatic waitDrain(input string name);
    int t = 0;
    while (expQ.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput({name, "_drained"}, expQ.size(), 0);
    checkOutput({name, "_level0"}, o_level, 0);
  endtask

  task automatic doReset();
    rst         = 1'b1;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: a pop happens on the edge after a negedge that sees valid && ready.
  initial begin
    byte unsigned exp;
    forever begin
      @(negedge clk);
      if (!rst && o_out_valid && i_out_ready && !ignoreOut) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out actual=0x%02h expected=none", o_out_data);
        end else begin
          exp = expQ.pop_front();
          checkOutput("out_data", o_out_data, exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    int acc;
    rst         = 1'b1;
    i_mode      = 2'd0;
    i_in_data   = 8'h00;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_level", o_level, 0);
    checkOutput("rst_out_valid", o_out_valid, 0);
    checkOutput("rst_in_ready", o_in_ready, 0);
    checkOutput("rst_sub_count", o_sub_count, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", o_in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] mode PASS");
    applyStimulus(2'd0, "Hello U", "Hello U", st);
    checkOutput("pass_stalls", st, 0);
    waitDrain("pass");
    checkOutput("pass_sub_count", o_sub_count, 0);

    $display("[TB] mode OWO");
    doReset();
    applyStimulus(2'd1, "hello you", "hellowo yowou", st);
    waitDrain("owo");
    checkOutput("owo_sub_count", o_sub_count, SC_OWO);

    $display("[TB] mode WAW");
    doReset();
    applyStimulus(2'd2, "rolling", "wowowwing", st);
    waitDrain("waw");
    checkOutput("waw_sub_count", o_sub_count, SC_WAW);

    $display("[TB] mode STUTTER");
    doReset();
    applyStimulus(2'd3, "hi Ron", "h-hi W-Wowon", st);
    waitDrain("stutter");
    checkOutput("stutter_sub_count", o_sub_count, SC_STU);

    $display("[TB] backpressure");
    doReset();
    i_out_ready = 1'b0;
    i_mode      = 2'd0;
    i_in_data   = 8'h61;
    i_in_valid  = 1'b1;
    acc = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_in_ready) acc++;
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    checkOutput("bp_accepted", acc, 6);
    checkOutput("bp_level", o_level, 6);
    checkOutput("bp_in_ready", o_in_ready, 0);
    pushExpected("aaaaaa");
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_level_after_pop", o_level, 5);
    checkOutput("bp_in_ready_return", o_in_ready, 1);
    @(posedge clk);
    #1;
    waitDrain("bp");

    $display("[TB] reset mid-expansion");
    doReset();
    i_out_ready = 1'b0;
    sendByte(2'd1, 8'h6F, st);
    checkOutput("mid_level_before", o_level, 1);
    checkOutput("mid_in_ready_busy", o_in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_level_after", o_level, 0);
    checkOutput("mid_out_valid_after", o_out_valid, 0);
    checkOutput("mid_in_ready_in_rst", o_in_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid_in_ready_released", o_in_ready, 1);
    i_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("mid_level_settled", o_level, 0);
    checkOutput("mid_out_valid_settled", o_out_valid, 0);

`ifdef UWU_STATS_EN
    $display("[TB] counter saturation");
    doReset();
    ignoreOut   = 1'b1;
    i_mode      = 2'd2;
    i_in_data   = 8'h72;
    i_in_valid  = 1'b1;
    repeat (65545) @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    checkOutput("sat_sub_count", o_sub_count, 32'h0000FFFF);
    repeat (4) @(posedge clk);
    #1;
    ignoreOut = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
